// File: rtl/msg_uart_tx_if.sv
// Bus-side port bundle for msg_uart_tx: chip-select, write strobe, word offset, data.
interface msg_uart_tx_if;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, output we, output addr, output wdata, input rdata);
    modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/msg_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, status and baud-divisor registers.
module msg_uart_tx #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic         clk,
    input  logic         rst,
    msg_uart_tx_if.slave bus,
    output logic         tx,
    output logic         busy
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nx;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, wr, push, pop;
    logic [15:0]   div, div_eff, frame_div, cyc;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic          bit_end, ovf, tx_d, tx_active;
    logic [6:0]    count_ext;
    logic [3:0]    count_sat;
    logic          unused_wdata;

    assign wr        = bus.sel & bus.we;
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign push      = wr && (bus.addr == 2'd0) && (!full || pop);
    assign div_eff   = (div == 16'd0) ? 16'd1 : div;
    assign bit_end   = (cyc == frame_div - 16'd1);
    assign tx_active = (state != IDLE);
    assign busy      = tx_active | !empty;
    assign count_ext = 7'(count);
    assign count_sat = (count_ext > 7'd15) ? 4'hF : count_ext[3:0];
    assign unused_wdata = ^bus.wdata[31:16];

    // Register read mux, zero when not selected
    always_comb begin
        bus.rdata = '0;
        if (bus.sel) begin
            case (bus.addr)
                2'd1:    bus.rdata = {24'b0, count_sat, ovf, tx_active, empty, full};
                2'd2:    bus.rdata = {16'b0, div};
                default: bus.rdata = '0;
            endcase
        end
    end

    // FIFO storage, written on accepted pushes
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wdata[7:0];
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Baud divisor register and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= 16'(CLKS_PER_BIT);
            ovf <= 1'b0;
        end else begin
            if (wr && bus.addr == 2'd2) div <= bus.wdata[15:0];
            if (wr && bus.addr == 2'd0 && full && !pop) ovf <= 1'b1;
            else if (wr && bus.addr == 2'd1 && bus.wdata[3]) ovf <= 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next state, pop request and next line level (tx is registered from tx_d)
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        tx_d     = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = START;
                    tx_d     = 1'b0;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    state_nx = DATA;
                    tx_d     = shift[0];
                end
            end
            DATA: begin
                tx_d = shift[0];
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                        tx_d     = 1'b1;
                    end else begin
                        tx_d = shift[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        state_nx = START;
                        tx_d     = 1'b0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Frame datapath: shift register, per-bit cycle counter, bit index, latched divisor
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift     <= '0;
            cyc       <= '0;
            bit_idx   <= '0;
            frame_div <= 16'(CLKS_PER_BIT);
        end else if (pop) begin
            shift     <= mem[rd_ptr];
            frame_div <= div_eff;
            cyc       <= '0;
            bit_idx   <= '0;
        end else if (state != IDLE) begin
            if (bit_end) begin
                cyc <= '0;
                if (state == START) bit_idx <= '0;
                if (state == DATA) begin
                    shift   <= {1'b0, shift[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                cyc <= cyc + 16'd1;
            end
        end
    end

    // Registered serial line, idles high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tx <= 1'b1;
        else      tx <= tx_d;
    end
endmodule
